// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the word-to-bit scan controller and its 1101 detector.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDrain,
    StDone
  } ctrl_state_e;

  typedef enum logic [2:0] {
    DetS0,
    DetS1,
    DetS2,
    DetS3,
    DetS4
  } det_state_e;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_scan_if.sv
// Handshake and data bundle between a word producer (master) and seq_scan_ctrl (slave).
interface seq_scan_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 2)
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;

  modport master (
    output start, abort, data_in,
    input  busy, done, match_count
  );

  modport slave (
    input  start, abort, data_in,
    output busy, done, match_count
  );

endinterface

// File: rtl/seq_detect_core.sv
// Overlapping Moore detector for PATTERN (1101); z is high only in the full-match state.
module seq_detect_core
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic adv,
  input  logic p1,
  output logic z
);

  det_state_e state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DetS0;
    end else if (clr) begin
      state_q <= DetS0;
    end else if (adv) begin
      case (state_q)
        DetS0:   state_q <= (p1 == PATTERN[3]) ? DetS1 : DetS0;
        DetS1:   state_q <= (p1 == PATTERN[2]) ? DetS2 : DetS0;
        // A mismatching 1 still leaves a "11" prefix.
        DetS2:   state_q <= (p1 == PATTERN[1]) ? DetS3 : DetS2;
        DetS3:   state_q <= (p1 == PATTERN[0]) ? DetS4 : DetS0;
        DetS4:   state_q <= p1 ? DetS2 : DetS0;
        default: state_q <= DetS0;
      endcase
    end
  end

  assign z = (state_q == DetS4);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serialises a word MSB-first into seq_detect_core and counts its matches.
// Define SEQ_SCAN_CHAIN_EN to carry detector state across consecutive words.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
  input logic       clk,
  input logic       reset,
  seq_scan_if.slave bus
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  ctrl_state_e      state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [BitW-1:0]  bit_q;
  logic [CNT_W-1:0] match_q;
  logic             adv_q;
  logic             busy_q;
  logic             done_q;

  logic accept;
  logic adv;
  logic clr;
  logic z;

  assign accept = (state_q == StIdle) && bus.start;
  // An aborting edge leaves the detector untouched.
  assign adv    = (state_q == StShift) && !bus.abort;

`ifdef SEQ_SCAN_CHAIN_EN
  assign clr = 1'b0;
`else
  assign clr = accept;
`endif

  seq_detect_core u_detect (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .adv   (adv),
    .p1    (sreg_q[WIDTH-1]),
    .z     (z)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      bit_q   <= '0;
      match_q <= '0;
      adv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      adv_q <= adv;
      // z lags adv by one edge, so gating with adv_q counts each consumed bit once.
      if (adv_q && z && (match_q != '1)) begin
        match_q <= match_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StShift;
            busy_q  <= 1'b1;
            sreg_q  <= bus.data_in;
            bit_q   <= '0;
            match_q <= '0;
          end
        end
        StShift: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            match_q <= '0;
          end else begin
            sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
            bit_q  <= bit_q + 1'b1;
            if (bit_q == LastBit) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            match_q <= '0;
          end else begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.match_count = match_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: stimulus queues expected counts, a monitor checks each done.
module tb_seq_scan_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = $clog2(W + 2);

  logic clk;
  logic reset;

  seq_scan_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    cnt;
    int    edge_no;
    string name;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_n      = 0;
  int   done_seen   = 0;
  int   done_run    = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      done_seen++;
      done_run++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done at edge %0d, expected none", edge_n);
      end else begin
        e = sb.pop_front();
        check({e.name, "_count"}, int'(bus.match_count), e.cnt);
        check({e.name, "_latency"}, edge_n, e.edge_no);
      end
    end else if (done_run != 0) begin
      check("done_width", done_run, 1);
      done_run = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 60) begin
      tick();
      n++;
    end
    check("idle_timeout", int'(bus.busy || bus.done), 0);
  endtask

  task automatic run_scan(input logic [W-1:0] word, input int exp, input string name);
    int target;
    int busy_cnt;
    int n;
    wait_idle();
    bus.data_in = word;
    bus.start   = 1'b1;
    sb.push_back('{exp, edge_n + W + 2, name});
    target = done_seen + 1;
    tick();
    bus.start = 1'b0;
    busy_cnt  = bus.busy ? 1 : 0;
    n = 0;
    while (done_seen < target && n < 3 * W) begin
      tick();
      if (bus.busy) busy_cnt++;
      n++;
    end
    check({name, "_done_seen"}, done_seen, target);
    check({name, "_busy_cycles"}, busy_cnt, W + 1);
    tick();
    check({name, "_count_hold"}, int'(bus.match_count), exp);
    check({name, "_done_low"}, int'(bus.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int target;
    int n;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.data_in = '0;
    #12;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_count", int'(bus.match_count), 0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    run_scan(16'hDB6D, 5, "db6d");
    run_scan(16'hD000, 1, "d000");
    run_scan(16'h0000, 0, "zeros");
    run_scan(16'hFFFF, 0, "ones");
    run_scan(16'h0006, 0, "w0006");
`ifdef SEQ_SCAN_CHAIN_EN
    run_scan(16'h8000, 1, "w8000_chain");
`else
    run_scan(16'h8000, 0, "w8000");
`endif

    // Abort after 8 shift edges.
    wait_idle();
    d0          = done_seen;
    bus.data_in = 16'hDB6D;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    check("abort_pre_busy", int'(bus.busy), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_count", int'(bus.match_count), 0);
    check("abort_done", int'(bus.done), 0);
    repeat (25) tick();
    check("abort_no_done", done_seen, d0);
    run_scan(16'hD000, 1, "post_abort");

    // start held high: one accepted scan every W+3 cycles.
    wait_idle();
    bus.data_in = 16'hD000;
    bus.start   = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{1, edge_n + W + 2 + i * (W + 3), "cont"});
    target = done_seen + 3;
    n = 0;
    while (done_seen < target && n < 5 * W) begin
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("cont_done_seen", done_seen, target);
    repeat (3) tick();
    check("cont_stop_busy", int'(bus.busy), 0);

    // Asynchronous reset in the middle of a scan.
    wait_idle();
    d0          = done_seen;
    bus.data_in = 16'hDB6D;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("midrst_pre_busy", int'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_count", int'(bus.match_count), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_no_done", done_seen, d0);
    run_scan(16'hDB6D, 5, "post_rst");

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

- Controller that feeds a parallel word, one bit per clock and MSB first, into an internal overlapping "1101" Moore sequence detector.
- Counts the detector's match pulses and reports the total with a start/busy/done handshake.
- Sits between a word-oriented producer and the bit-serial detector datapath, so software-visible logic never drives P1 bit-by-bit.

## Interface
- WIDTH, 16, bits per scanned word (≥4)
- CNT_W, $clog2(WIDTH+2), width of match_count
- clk  input  1  rising-edge clock, single domain
- reset  input  1  asynchronous, active-low reset
- start  input  1  request scan; sampled only in IDLE
- abort  input  1  cancel scan; honoured in SHIFT and DRAIN
- data_in  input  WIDTH  word to scan; captured on the accepting edge
- busy  output  1  high in SHIFT and DRAIN
- done  output  1  one-cycle pulse, high only in DONE
- match_count  output  CNT_W  matches found in last completed scan

## Operation
- Controller FSM: IDLE, SHIFT, DRAIN, DONE.
- IDLE -> SHIFT when start=1:
  - load shift register from data_in
  - clear bit counter and match_count
  - clear detector to S0 (see Configuration)
- SHIFT:
  - P1 to the detector = shift register MSB; detector advances every edge (adv=1); register shifts left
  - after WIDTH edges -> DRAIN
- DRAIN: one edge, adv=0, captures the final z -> DONE.
- DONE: done=1 for one cycle -> IDLE unconditionally. start in DONE is ignored.
- Detector core (Moore, overlapping, pattern 1101), states S0 none, S1 "1", S2 "11", S3 "110", S4 "1101"; z=1 only in S4:
  - S0: 1->S1, 0->S0
  - S1: 1->S2, 0->S0
  - S2: 1->S2, 0->S3
  - S3: 1->S4, 0->S0
  - S4: 1->S2, 0->S0
  - state held when adv=0
- Counting:
  - adv_q = adv registered
  - match_count increments on an edge when adv_q=1 and z=1
  - an idle S4 is never counted twice
- match_count saturates at all-ones; unreachable with the default CNT_W.
- abort in SHIFT/DRAIN -> IDLE next edge:
  - no done pulse
  - match_count cleared to 0
  - detector state left as is
- abort in IDLE or DONE has no effect; abort has priority over the DRAIN->DONE transition.
- start while busy is ignored; data_in is not re-sampled.

## Timing
- Reset values (async, reset=0):
  - FSM=IDLE, busy=0, done=0, match_count=0
  - shift register=0, detector=S0, adv_q=0
- start sampled at edge E0: busy=1 from E0 through E(WIDTH+1); DRAIN entered at E(WIDTH).
- done=1 in the cycle following E(WIDTH+1), i.e. WIDTH+2 cycles after E0.
- Minimum start-to-start spacing: WIDTH+3 cycles.
- match_count is stable from the done cycle until the next accepted start.
- reset asserted mid-scan: all outputs return to reset values immediately, with no done.

## Configuration
- SEQ_SCAN_CHAIN_EN defined:
  - detector state is NOT cleared on start; it carries over from the previous word
  - a pattern straddling two consecutive words is counted in the second word's scan
- SEQ_SCAN_CHAIN_EN undefined: detector forced to S0 on every accepted start; words are independent.

## Structure
- Package seq_scan_pkg holds:
  - controller state enum (IDLE/SHIFT/DRAIN/DONE)
  - detector state enum (S0–S4)
  - PATTERN constant 4'b1101
- One sub-module, seq_detect_core:
  - ports clk, reset, clr, adv, p1, z
  - pure Moore FSM, one always block for state and a combinational z decode
- Controller, shift register, bit counter and match counter live in seq_scan_ctrl.

## Test plan
- WIDTH=16, data_in=16'hDB6D, start 1 cycle -> busy 17 cycles, done pulse 18 cycles after the start edge, match_count=5.
- data_in=16'hD000 -> match_count=1; data_in=16'h0000 and 16'hFFFF -> match_count=0 each.
- Word 16'h0006 then word 16'h8000:
  - with SEQ_SCAN_CHAIN_EN, second scan match_count=1
  - without, 0
- start 16'hDB6D, abort after 8 SHIFT cycles -> busy low next edge, no done, match_count=0; a following scan of 16'hD000 yields 1 (non-chain build).
- start held high continuously with 16'hD000 -> one scan per 19 cycles, each done with match_count=1; start during busy/DONE is not accepted.
- reset pulled low mid-SHIFT -> busy/done/match_count=0 asynchronously; after release, a scan of 16'hDB6D returns 5.
